// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle datapath control: opcodes, ALUOp,
// ALU operand-B and PC source selects, and the controller state encoding.
// The ALU controller imports the same package, so both blocks always agree
// on these codes.
package multi_cycle_controller_pkg;

  localparam logic [3:0] OP_LOAD    = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0001;
  localparam logic [3:0] OP_JUMP    = 4'b0010;
  localparam logic [3:0] OP_BRANCHZ = 4'b0100;
  localparam logic [3:0] OP_CTYPE   = 4'b1000;
  localparam logic [3:0] OP_ADDI    = 4'b1100;
  localparam logic [3:0] OP_SUBI    = 4'b1101;
  localparam logic [3:0] OP_ANDI    = 4'b1110;
  localparam logic [3:0] OP_ORI     = 4'b1111;

  localparam logic [2:0] ALUOP_BRZ   = 3'b000;
  localparam logic [2:0] ALUOP_CTYPE = 3'b001;
  localparam logic [2:0] ALUOP_NOP   = 3'b011;
  localparam logic [2:0] ALUOP_ADDI  = 3'b100;
  localparam logic [2:0] ALUOP_SUBI  = 3'b101;
  localparam logic [2:0] ALUOP_ANDI  = 3'b110;
  localparam logic [2:0] ALUOP_ORI   = 3'b111;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_C, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM, CLS_JUMP, CLS_BRANCH, CLS_CTYPE, CLS_IMM, CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t op_class(input logic [3:0] op);
    case (op)
      OP_LOAD, OP_STORE:                op_class = CLS_MEM;
      OP_JUMP:                          op_class = CLS_JUMP;
      OP_BRANCHZ:                       op_class = CLS_BRANCH;
      OP_CTYPE:                         op_class = CLS_CTYPE;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: op_class = CLS_IMM;
      default:                          op_class = CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] imm_aluop(input logic [3:0] op);
    case (op)
      OP_ADDI: imm_aluop = ALUOP_ADDI;
      OP_SUBI: imm_aluop = ALUOP_SUBI;
      OP_ANDI: imm_aluop = ALUOP_ANDI;
      OP_ORI:  imm_aluop = ALUOP_ORI;
      default: imm_aluop = ALUOP_NOP;
    endcase
  endfunction

  // C-type nop (01000000) and register-window ops (Func[7]=1) produce no
  // register result.
  function automatic logic ctype_writes(input logic [7:0] func);
    ctype_writes = !((func == 8'b01000000) || func[7]);
  endfunction

endpackage

// File: rtl/multi_cycle_controller.sv
// Multi-cycle datapath controller: Moore FSM sequencing fetch, decode,
// execute, memory and write-back steps. Only the memory-completion strobes
// (FETCH, MEM_RD, MEM_WR) look at MemReady combinationally.
// Ports:
//   clk, rst (sync, active-low)
//   Opcode[3:0], Func[7:0]  instruction register fields (stable after IRWrite)
//   Zero                    ALU zero flag, used by BRANCH
//   MemReady                memory completes the pending access this cycle
//   PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemToReg, ALUSrcA
//   ALUSrcB[1:0], PCSrc[1:0], ALUOp[2:0], IllegalOp
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Opcode,
  input  logic [7:0] Func,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic       IllegalOp
);

  state_t    state, next_state;
  op_class_t cls;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    cls        = op_class(Opcode);
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PCSRC_ALU;
    ALUOp      = ALUOP_NOP;
    IllegalOp  = 1'b0;
    // Outputs are forced quiet while reset is held, even though the state
    // register already sits in FETCH.
    if (rst) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            ALUSrcB    = SRCB_ONE;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          case (cls)
            CLS_MEM:    next_state = S_MEM_ADDR;
            CLS_JUMP:   next_state = S_JUMP;
            CLS_BRANCH: next_state = S_BRANCH;
            CLS_CTYPE:  next_state = S_EXEC_C;
            CLS_IMM:    next_state = S_EXEC_I;
            default: begin
              IllegalOp  = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_EXEC_C: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_REG;
          ALUOp      = ALUOP_CTYPE;
          next_state = S_WB_ALU;
        end
        S_EXEC_I: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          ALUOp      = imm_aluop(Opcode);
          next_state = S_WB_ALU;
        end
        S_WB_ALU: begin
          // ALU controls stay as in EXEC so the result is still on the bus.
          ALUSrcA = 1'b1;
          if (cls == CLS_CTYPE) begin
            ALUSrcB  = SRCB_REG;
            ALUOp    = ALUOP_CTYPE;
            RegWrite = ctype_writes(Func);
          end else begin
            ALUSrcB  = SRCB_IMM;
            ALUOp    = imm_aluop(Opcode);
            RegWrite = 1'b1;
          end
          next_state = S_FETCH;
        end
        S_MEM_ADDR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = (Opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (MemReady) next_state = S_MEM_WB;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (MemReady) next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_REG;
          ALUOp      = ALUOP_BRZ;
          PCSrc      = PCSRC_BR;
          PCWrite    = Zero;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = PCSRC_JMP;
          PCWrite    = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset that is synchronous and active-low.
REQ-003 SHALL have port Opcode, input, 4 bits: opcode field of the instruction register.
REQ-004 SHALL have port Func, input, 8 bits: C-type function field.
REQ-005 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port MemReady, input, 1 bit: memory completes the pending access this cycle.
REQ-007 SHALL have outputs PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemToReg, ALUSrcA, each 1 bit: standard multi-cycle datapath strobes and selects.
REQ-008 SHALL have outputs ALUSrcB (2 bits: 00 reg, 01 const 1, 10 sign-ext imm) and PCSrc (2 bits: 00 ALU, 01 branch target, 10 jump target).
REQ-009 SHALL have output ALUOp, 3 bits: 000 branchz, 001 C-type, 011 load/store/jump (nop), 100 addi, 101 subi, 110 andi, 111 ori.
REQ-010 SHALL have output IllegalOp, 1 bit: one-cycle pulse on an undefined opcode.

Function
REQ-011 SHALL decode opcodes: LOAD 0000, STORE 0001, JUMP 0010, BRANCHZ 0100, CTYPE 1000, ADDI 1100, SUBI 1101, ANDI 1110, ORI 1111; all others illegal.
REQ-012 SHALL implement states FETCH, DECODE, EXEC_C, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP.
REQ-013 Outputs SHALL be Moore-style from state, except the FETCH/MEM_RD/MEM_WR completion strobes, which are gated by MemReady; unlisted outputs are 0 and ALUOp is 011.
REQ-014 FETCH SHALL assert MemRead, IorD=0, and hold them every cycle until MemReady=1; in the MemReady cycle it SHALL assert IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, and PCSrc=00, then go to DECODE.
REQ-015 DECODE SHALL last one cycle and branch: LOAD/STORE->MEM_ADDR, JUMP->JUMP, BRANCHZ->BRANCH, CTYPE->EXEC_C, ADDI..ORI->EXEC_I, illegal->FETCH with IllegalOp=1.
REQ-016 EXEC_C SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=001, then go to WB_ALU.
REQ-017 EXEC_I SHALL drive ALUSrcA=1, ALUSrcB=10, and ALUOp from the opcode (100/101/110/111), then go to WB_ALU.
REQ-018 WB_ALU SHALL hold the EXEC ALU controls and assert RegWrite with MemToReg=0, except for CTYPE with Func=01000000 or Func[7]=1 (nop/window), where RegWrite SHALL be 0; it then goes to FETCH.
REQ-019 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=011, then go to MEM_RD (LOAD) or MEM_WR (STORE).
REQ-020 MEM_RD SHALL hold MemRead=1 and IorD=1 until MemReady, then go to MEM_WB; MEM_WB SHALL assert RegWrite with MemToReg=1, then go to FETCH.
REQ-021 MEM_WR SHALL hold MemWrite=1 and IorD=1 until MemReady, then go to FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=000, PCSrc=01, and PCWrite=Zero, then go to FETCH.
REQ-023 JUMP SHALL drive PCSrc=10 and PCWrite=1, then go to FETCH.
REQ-024 Cycle counts with zero memory wait SHALL be: C-type/imm 4, load 5, store 4, branch/jump 3; each MemReady-low cycle adds 1.
REQ-025 MemRead and MemWrite SHALL never be asserted together, and neither SHALL drop before MemReady is sampled high.

Reset
REQ-026 rst=0 at a clock edge SHALL force state to FETCH in that edge, including mid-access, abandoning the access.
REQ-027 While rst=0, all outputs SHALL be 0 and ALUOp SHALL be 011; on release, FETCH behaviour starts on the next cycle.

Structure
REQ-028 Opcode, ALUOp, ALUSrcB/PCSrc encodings and state encodings SHALL live in a shared package also used by the ALU controller.
REQ-029 The block SHALL be a single module with no sub-modules; an optional opcode-class decode function SHALL live in the package.

Verification
REQ-030 Reset then ADDI with MemReady=1 each cycle -> IRWrite/PCWrite in cycle 1, ALUOp=100 in cycles 3-4, RegWrite only in cycle 4, FETCH in cycle 5.
REQ-031 LOAD with MemReady low for 2 cycles in FETCH and 3 in MEM_RD -> MemRead held throughout, total 10 cycles, RegWrite with MemToReg=1 once.
REQ-032 BRANCHZ with Zero=1 then Zero=0 -> PCWrite=1 with PCSrc=01 in the first case; PCWrite=0 in the second; both 3 cycles.
REQ-033 CTYPE with Func=10000010, then Func=00000010 -> RegWrite=0 for the first, RegWrite=1 for the second; ALUOp=001 for both.
REQ-034 Opcode=0111 -> IllegalOp pulse in DECODE, no RegWrite/MemWrite, FETCH next cycle.
REQ-035 rst low during MEM_WR wait -> MemWrite deasserts at that edge; FETCH after release.
